// File: rtl/arb_somador2comp_pkg.sv
// rtl/arb_somador2comp_pkg.sv - shared types and defaults for the adder arbiter
package arb_somador2comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int N_DEF       = 5;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF) + 1;

endpackage

// File: rtl/arb_somador2comp_rr.sv
// rtl/arb_somador2comp_rr.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    // On contention the requester that was not served last wins.
    assign gnt_idx   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/arb_somador2comp.sv
// rtl/arb_somador2comp.sv - round-robin sequencer sharing one 2's-complement adder
module arb_somador2comp
    import arb_somador2comp_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         RESET_n,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    output logic         ack0,
    output logic [N:0]   res0,
    output logic         err0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         ack1,
    output logic [N:0]   res1,
    output logic         err1,
    output logic         S,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    input  logic         done,
    input  logic [N:0]   result,
    output logic         busy,
    output logic         grant
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic          to_flag;
    logic          last;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          done_rise;
    logic          to_hit;

    rr_arb2 u_rr (
        .req0      (req0),
        .req1      (req1),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Only a fresh edge completes an operation; a stale level-high done is ignored.
    assign done_rise = done & ~done_q;
    assign to_hit    = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_valid) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (done_rise || to_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            done_q  <= 1'b0;
            cnt     <= '0;
            to_flag <= 1'b0;
            last    <= 1'b1;
            grant   <= 1'b0;
            a       <= '0;
            b       <= '0;
            res0    <= '0;
            res1    <= '0;
        end else begin
            done_q <= done;
            case (state)
                IDLE: if (gnt_valid) begin
                    grant <= gnt_idx;
                    a     <= gnt_idx ? a1 : a0;
                    b     <= gnt_idx ? b1 : b0;
                end
                START: begin
                    cnt     <= '0;
                    to_flag <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (done_rise) begin
                        if (grant) res1 <= result;
                        else       res0 <= result;
                    end else if (to_hit) begin
                        to_flag <= 1'b1;
                    end
                end
                RESP:    last <= grant;
                default: ;
            endcase
        end
    end

    assign S    = (state == START);
    assign busy = (state != IDLE);
    assign ack0 = (state == RESP) && !grant;
    assign ack1 = (state == RESP) &&  grant;
    assign err0 = ack0 && to_flag;
    assign err1 = ack1 && to_flag;

endmodule
